// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: PC sequencing, load-use stalls, control flushes and memory freeze.
// Optional stall performance counter is built only when PIPE_HAZARD_PERF_EN is defined.
module pipe_hazard_ctrl #(
   parameter int unsigned MEM_TIMEOUT = 64,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             start_i,
   input  logic [4:0]       id_rs_i,
   input  logic [4:0]       id_rt_i,
   input  logic             ex_memread_i,
   input  logic [4:0]       ex_rt_i,
   input  logic             branch_taken_i,
   input  logic             jump_i,
   input  logic             dmem_req_i,
   input  logic             dmem_ack_i,
   output logic             pc_write_o,
   output logic [1:0]       pc_sel_o,
   output logic             ifid_write_o,
   output logic             ifid_flush_o,
   output logic             idex_bubble_o,
   output logic             pipe_freeze_o,
   output logic             err_o,
   output logic [CNT_W-1:0] stall_cnt_o
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      RUN      = 2'd1,
      MEM_WAIT = 2'd2,
      ERR      = 2'd3
   } state_t;

   localparam logic [1:0] PC_SEQ    = 2'b00;
   localparam logic [1:0] PC_BRANCH = 2'b01;
   localparam logic [1:0] PC_JUMP   = 2'b10;
   localparam logic [7:0] TMO_LIMIT = 8'(MEM_TIMEOUT);

   state_t     state_q, state_d;
   logic [7:0] tmo_q, tmo_d;

   logic mem_stall;
   logic load_use;
   logic ctrl_hazard;

   assign mem_stall   = dmem_req_i && !dmem_ack_i;
   assign load_use    = ex_memread_i && (ex_rt_i != 5'd0) &&
                        ((ex_rt_i == id_rs_i) || (ex_rt_i == id_rt_i));
   assign ctrl_hazard = jump_i || branch_taken_i;

   // NOTE: every signal driven here gets a default first, so no path can infer a latch.
   always_comb begin
      state_d       = state_q;
      tmo_d         = tmo_q;
      pc_write_o    = 1'b0;
      pc_sel_o      = PC_SEQ;
      ifid_write_o  = 1'b0;
      ifid_flush_o  = 1'b0;
      idex_bubble_o = 1'b0;
      pipe_freeze_o = 1'b0;
      err_o         = 1'b0;

      case (state_q)
         IDLE: begin
            if (start_i) state_d = RUN;
         end
         RUN: begin
            if (mem_stall) begin
               pipe_freeze_o = 1'b1;
               state_d       = MEM_WAIT;
               tmo_d         = 8'd1;
            end else if (load_use) begin
               idex_bubble_o = 1'b1;
            end else if (ctrl_hazard) begin
               pc_write_o   = 1'b1;
               ifid_write_o = 1'b1;
               ifid_flush_o = 1'b1;
               pc_sel_o     = jump_i ? PC_JUMP : PC_BRANCH;
            end else begin
               pc_write_o   = 1'b1;
               ifid_write_o = 1'b1;
            end
            if (!start_i) state_d = IDLE;
         end
         MEM_WAIT: begin
            // The ack cycle is still frozen; the pipe moves on the cycle after.
            pipe_freeze_o = 1'b1;
            if (dmem_ack_i) begin
               state_d = RUN;
            end else if (tmo_q >= TMO_LIMIT) begin
               state_d = ERR;
            end else begin
               tmo_d = tmo_q + 8'd1;
            end
            if (!start_i) state_d = IDLE;
         end
         ERR: begin
            pipe_freeze_o = 1'b1;
            err_o         = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q <= IDLE;
         tmo_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         tmo_q   <= tmo_d;
      end
   end

`ifdef PIPE_HAZARD_PERF_EN
   logic [CNT_W-1:0] stall_cnt_q;
   logic             stall_cycle;

   assign stall_cycle = ((state_q == RUN) || (state_q == MEM_WAIT)) && !pc_write_o;

   // Saturating: a stuck count is more useful to software than a wrapped one.
   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         stall_cnt_q <= '0;
      end else if (stall_cycle && (stall_cnt_q != '1)) begin
         stall_cnt_q <= stall_cnt_q + 1'b1;
      end
   end

   assign stall_cnt_o = stall_cnt_q;
`else
   assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed test-plan steps followed by randomized
// traffic, all compared against a behavioural model of the hazard rules.
module tb_pipe_hazard_ctrl;

   localparam int unsigned T_OUT = 4;
   localparam int unsigned CW    = 3;
   localparam int          SAT   = (1 << CW) - 1;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          start_i;
   logic [4:0]    id_rs_i, id_rt_i, ex_rt_i;
   logic          ex_memread_i, branch_taken_i, jump_i, dmem_req_i, dmem_ack_i;
   logic          pc_write_o, ifid_write_o, ifid_flush_o, idex_bubble_o, pipe_freeze_o, err_o;
   logic [1:0]    pc_sel_o;
   logic [CW-1:0] stall_cnt_o;

   int tests = 0;
   int fails = 0;

   // Behavioural model: running / waiting-on-memory / errored flags plus counts.
   bit m_run, m_wait, m_err;
   int m_wcnt, m_stalls;

   // Expected outputs for the current cycle.
   bit   e_pcw, e_ifw, e_flush, e_bub, e_frz, e_err;
   int   e_sel, e_cnt;

   pipe_hazard_ctrl #(.MEM_TIMEOUT(T_OUT), .CNT_W(CW)) dut (
      .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
      .id_rs_i(id_rs_i), .id_rt_i(id_rt_i), .ex_memread_i(ex_memread_i), .ex_rt_i(ex_rt_i),
      .branch_taken_i(branch_taken_i), .jump_i(jump_i),
      .dmem_req_i(dmem_req_i), .dmem_ack_i(dmem_ack_i),
      .pc_write_o(pc_write_o), .pc_sel_o(pc_sel_o), .ifid_write_o(ifid_write_o),
      .ifid_flush_o(ifid_flush_o), .idex_bubble_o(idex_bubble_o),
      .pipe_freeze_o(pipe_freeze_o), .err_o(err_o), .stall_cnt_o(stall_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   function automatic void model_outputs();
      bit hazard_load;
      {e_pcw, e_ifw, e_flush, e_bub, e_frz, e_err} = '0;
      e_sel = 0;
`ifdef PIPE_HAZARD_PERF_EN
      e_cnt = m_stalls;
`else
      e_cnt = 0;
`endif
      hazard_load = ex_memread_i && ex_rt_i != 0 && (ex_rt_i == id_rs_i || ex_rt_i == id_rt_i);
      if (m_err) begin
         e_frz = 1; e_err = 1;
      end else if (!m_run) begin
         // idle: everything off
      end else if (m_wait || (dmem_req_i && !dmem_ack_i)) begin
         e_frz = 1;
      end else if (hazard_load) begin
         e_bub = 1;
      end else begin
         e_pcw = 1; e_ifw = 1;
         if (jump_i) begin e_sel = 2; e_flush = 1; end
         else if (branch_taken_i) begin e_sel = 1; e_flush = 1; end
      end
   endfunction

   function automatic void model_edge();
      if (m_err) return;
      if (!m_run) begin
         m_run = start_i;
         return;
      end
      if (!e_pcw && m_stalls < SAT) m_stalls++;
      if (!start_i) begin
         m_run = 0; m_wait = 0;
      end else if (m_wait) begin
         if (dmem_ack_i) m_wait = 0;
         else if (m_wcnt >= T_OUT) begin m_err = 1; m_wait = 0; end
         else m_wcnt++;
      end else if (dmem_req_i && !dmem_ack_i) begin
         m_wait = 1; m_wcnt = 1;
      end
   endfunction

   task automatic check_all(input string tag);
      model_outputs();
      check({tag, ".pc_write"},    int'(pc_write_o),    int'(e_pcw));
      check({tag, ".pc_sel"},      int'(pc_sel_o),      e_sel);
      check({tag, ".ifid_write"},  int'(ifid_write_o),  int'(e_ifw));
      check({tag, ".ifid_flush"},  int'(ifid_flush_o),  int'(e_flush));
      check({tag, ".idex_bubble"}, int'(idex_bubble_o), int'(e_bub));
      check({tag, ".freeze"},      int'(pipe_freeze_o), int'(e_frz));
      check({tag, ".err"},         int'(err_o),         int'(e_err));
      check({tag, ".stall_cnt"},   int'(stall_cnt_o),   e_cnt);
   endtask

   // Called at posedge+1: inputs already set; checks at negedge, then advances one edge.
   task automatic step(input string tag);
      #4;
      check_all(tag);
      @(posedge clk_i);
      model_edge();
      #1;
   endtask

   task automatic set_in(input bit st, input int rs, input int rt, input bit mr, input int ert,
                         input bit br, input bit jp, input bit rq, input bit ak);
      start_i = st; id_rs_i = 5'(rs); id_rt_i = 5'(rt); ex_memread_i = mr; ex_rt_i = 5'(ert);
      branch_taken_i = br; jump_i = jp; dmem_req_i = rq; dmem_ack_i = ak;
   endtask

   // Asynchronous reset pulse in the middle of a cycle, with start low across the next edge.
   task automatic do_reset(input string tag);
      start_i = 0;
      rst_i = 0;
      m_run = 0; m_wait = 0; m_err = 0; m_wcnt = 0; m_stalls = 0;
      #1;
      check_all(tag);
      #1 rst_i = 1;
      @(posedge clk_i);
      #1;
   endtask

   initial begin
      rst_i = 1;
      set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge clk_i); #1;
      do_reset("reset");

      set_in(1, 1, 2, 0, 3, 0, 0, 0, 0);
      step("idle_first");
      for (int i = 0; i < 3; i++) step("run_plain");

      set_in(1, 5, 7, 1, 5, 1, 0, 0, 0);
      step("load_use_vs_branch");
      set_in(1, 0, 7, 1, 0, 1, 0, 0, 0);
      step("r0_no_stall_branch");
      set_in(1, 4, 6, 0, 9, 1, 1, 0, 0);
      step("jump_wins");

      set_in(1, 1, 2, 0, 3, 0, 0, 1, 0);
      step("mem_req");
      step("mem_wait1");
      step("mem_wait2");
      dmem_ack_i = 1;
      step("mem_ack");
      set_in(1, 1, 2, 0, 3, 0, 0, 0, 0);
      step("mem_resume");

      set_in(1, 1, 2, 0, 3, 0, 0, 1, 0);
      for (int i = 0; i < T_OUT + 1; i++) step("timeout_wait");
      step("err_state");
      start_i = 0;
      step("err_start_low");
      step("err_sticky");
      do_reset("reset_in_err");

      // Randomized traffic, re-reset every block so error traps do not end exploration.
      for (int blk = 0; blk < 12; blk++) begin
         for (int c = 0; c < 40; c++) begin
            set_in($urandom_range(0, 15) != 0,
                   $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 1) == 1,
                   $urandom_range(0, 3), $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                   m_wait ? 1'b1 : ($urandom_range(0, 5) == 0),
                   $urandom_range(0, 2 + blk % 4) == 0);
            step("rand");
         end
         do_reset("rand_reset");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
